kernel_stream_feeder: RTL and testbench

Stream source that drives the input side of a generated kernel top (e.g. kernelTop_kernel_A). On `start` it reads `nelems` element pairs from two synchronous-read local memories, one port per input vector, and presents them as two parallel input streams under the kernel's `ivalid`/`iready` handshake. A 2-entry output FIFO absorbs the one-cycle memory read latency, so the feeder sustains one element per cycle under kernel backpressure.

---
 rtl/kernel_stream_feeder_pkg.sv | 16 +
 rtl/kernel_stream_feeder_fifo.sv | 55 +++++
 rtl/kernel_stream_feeder.sv | 121 ++++++++++++
 tb/tb_kernel_stream_feeder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/kernel_stream_feeder_pkg.sv
// Shared constants and types for the kernel stream feeder and its output FIFO.
package kernel_stream_feeder_pkg;

   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned FIFO_CNTW  = 2;
   // Wide enough for fifo_count + inflight (at most 3)
   localparam int unsigned CREDITW    = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH,
      ST_DONE
   } feeder_state_t;

endpackage

// File: rtl/kernel_stream_feeder_fifo.sv
// Two-entry register FIFO holding {stream1, stream0} pairs between memory and kernel.
module stream_fifo2
   import kernel_stream_feeder_pkg::*;
#(
   parameter int unsigned W = 64
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_push,
   input  logic                 i_pop,
   input  logic [W-1:0]         i_din,
   output logic [W-1:0]         o_dout,
   output logic                 o_empty,
   output logic                 o_full,
   output logic [FIFO_CNTW-1:0] o_count
);

   logic [W-1:0]         r_mem [FIFO_DEPTH];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [FIFO_CNTW-1:0] r_count;
   logic                 w_push;
   logic                 w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == FIFO_CNTW'(FIFO_DEPTH));
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop & ~o_empty;
   // A full FIFO still takes a push when the head leaves in the same cycle
   assign w_push  = i_push & (~o_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_mem    <= '{default: '0};
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + FIFO_CNTW'(1);
            2'b01:   r_count <= r_count - FIFO_CNTW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/kernel_stream_feeder.sv
// Streams nelems element pairs from two synchronous-read memories into a kernel's
// ivalid/iready input, with a credit-limited 2-entry FIFO hiding the read latency.
module kernel_stream_feeder
   import kernel_stream_feeder_pkg::*;
#(
   parameter int unsigned STREAMW = 32,
   parameter int unsigned ADDRW   = 10
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [ADDRW:0]     i_nelems,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_rd_en,
   output logic [ADDRW-1:0]   o_rd_addr,
   input  logic [STREAMW-1:0] i_rd_data0,
   input  logic [STREAMW-1:0] i_rd_data1,
   output logic               o_ovalid,
   input  logic               i_oready,
   output logic [STREAMW-1:0] o_vin0_s0,
   output logic [STREAMW-1:0] o_vin1_s0
);

   localparam logic [ADDRW:0] CNT_ONE = (ADDRW+1)'(1);

   feeder_state_t         r_state;
   logic [ADDRW:0]        r_nelems;
   logic [ADDRW:0]        r_issued;
   logic [ADDRW:0]        r_accepted;
   logic                  r_inflight;
   logic                  r_busy;
   logic                  r_done;

   logic                  w_rd_en;
   logic                  w_pop;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_credit_ok;
   logic [FIFO_CNTW-1:0]  w_count;
   logic [CREDITW-1:0]    w_pending;
   logic [2*STREAMW-1:0]  w_dout;

   assign w_pop       = ~w_empty & i_oready;
   // Slots already spoken for once this cycle's push and pop have settled
   assign w_pending   = CREDITW'(w_count) + CREDITW'(r_inflight) - CREDITW'(w_pop);
   assign w_credit_ok = (w_pending < CREDITW'(FIFO_DEPTH));
   assign w_rd_en     = (r_state == ST_RUN) && (r_issued < r_nelems) && w_credit_ok;

   stream_fifo2 #(
      .W (2*STREAMW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (r_inflight),
      .i_pop   (w_pop),
      .i_din   ({i_rd_data1, i_rd_data0}),
      .o_dout  (w_dout),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (w_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_nelems   <= '0;
         r_issued   <= '0;
         r_accepted <= '0;
         r_inflight <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_inflight <= w_rd_en;
         r_done     <= 1'b0;
         if (w_rd_en) r_issued <= r_issued + CNT_ONE;
         if (w_pop)   r_accepted <= r_accepted + CNT_ONE;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_nelems   <= i_nelems;
                  r_issued   <= '0;
                  r_accepted <= '0;
                  if (i_nelems == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= ST_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (w_rd_en && (r_issued + CNT_ONE == r_nelems)) r_state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               if (w_pop && (r_accepted + CNT_ONE == r_nelems)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE:  r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) assert (!(r_inflight && w_full && !w_pop));
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_rd_en   = w_rd_en;
   assign o_rd_addr = r_issued[ADDRW-1:0];
   assign o_ovalid  = ~w_empty;
   assign o_vin0_s0 = w_dout[STREAMW-1:0];
   assign o_vin1_s0 = w_dout[2*STREAMW-1:STREAMW];

endmodule

// File: tb/tb_kernel_stream_feeder.sv
// Directed and randomized runs of kernel_stream_feeder against a queue-based model.
module tb_kernel_stream_feeder;

   localparam int unsigned STREAMW = 32;
   localparam int unsigned ADDRW   = 10;
   localparam int          MEMN    = 1 << ADDRW;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [ADDRW:0]     nelems;
   logic               busy;
   logic               done;
   logic               rd_en;
   logic [ADDRW-1:0]   rd_addr;
   logic [STREAMW-1:0] rd_data0 = '0;
   logic [STREAMW-1:0] rd_data1 = '0;
   logic               ovalid;
   logic               oready;
   logic [STREAMW-1:0] vin0_s0;
   logic [STREAMW-1:0] vin1_s0;

   logic [STREAMW-1:0]   mem0 [MEMN];
   logic [STREAMW-1:0]   mem1 [MEMN];
   logic [2*STREAMW-1:0] exp_q [$];

   int checks = 0;
   int errors = 0;
   int issued_m, accepted_m, n_done, run_n;
   logic        prev_ov, prev_rdy;
   logic [63:0] prev_data;

   kernel_stream_feeder #(
      .STREAMW (STREAMW),
      .ADDRW   (ADDRW)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_nelems   (nelems),
      .o_busy     (busy),
      .o_done     (done),
      .o_rd_en    (rd_en),
      .o_rd_addr  (rd_addr),
      .i_rd_data0 (rd_data0),
      .i_rd_data1 (rd_data1),
      .o_ovalid   (ovalid),
      .i_oready   (oready),
      .o_vin0_s0  (vin0_s0),
      .o_vin1_s0  (vin1_s0)
   );

   always #5 clk = ~clk;

   // Synchronous-read memories: data appears the cycle after rd_en
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data0 <= mem0[rd_addr];
         rd_data1 <= mem1[rd_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle protocol checks against the model's read/accept counts and data queue
   task automatic monitor();
      logic [63:0] cur;
      cur = {vin1_s0, vin0_s0};
      if (prev_ov && !prev_rdy) begin
         chk("hold_valid", 64'(ovalid), 64'd1);
         chk("hold_data", cur, prev_data);
      end
      chk("read_budget", 64'((issued_m - accepted_m) <= 2), 64'd1);
      if (rd_en) begin
         chk("rd_addr", 64'(rd_addr), 64'(issued_m % MEMN));
         chk("rd_overrun", 64'(issued_m < run_n), 64'd1);
         issued_m++;
      end
      if (ovalid && oready) begin
         chk("beat_in_range", 64'(accepted_m < run_n), 64'd1);
         if (exp_q.size() > 0) chk("data", cur, 64'(exp_q.pop_front()));
         accepted_m++;
      end
      if (done) n_done++;
      prev_ov   = ovalid;
      prev_rdy  = oready;
      prev_data = cur;
   endtask

   task automatic step(input logic rdy, input logic st, input logic r);
      @(posedge clk);
      #1;
      oready = rdy;
      start  = st;
      rst    = r;
      #1;
      monitor();
   endtask

   task automatic check_quiet(input string tag);
      chk({tag, ":busy"},    64'(busy),    64'd0);
      chk({tag, ":done"},    64'(done),    64'd0);
      chk({tag, ":rd_en"},   64'(rd_en),   64'd0);
      chk({tag, ":rd_addr"}, 64'(rd_addr), 64'd0);
      chk({tag, ":ovalid"},  64'(ovalid),  64'd0);
      chk({tag, ":vin0"},    64'(vin0_s0), 64'd0);
      chk({tag, ":vin1"},    64'(vin1_s0), 64'd0);
   endtask

   function automatic logic rdy_of(input int mode, input int c);
      case (mode)
         0:       return 1'b1;
         1:       return (c % 3) == 0;
         2:       return !(c >= 2 && c <= 20);
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   task automatic prep(input int n, input bit pat);
      for (int i = 0; i < MEMN; i++) begin
         mem0[i] = pat ? STREAMW'(32'h10 + i) : STREAMW'($urandom);
         mem1[i] = pat ? STREAMW'(32'h20 + i) : STREAMW'($urandom);
      end
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back({mem1[i], mem0[i]});
      issued_m   = 0;
      accepted_m = 0;
      n_done     = 0;
      run_n      = n;
      nelems     = (ADDRW+1)'(n);
   endtask

   task automatic run(input string name, input int n, input int mode, input int start2, input bit pat);
      int done_c;
      prep(n, pat);
      step(rdy_of(mode, 0), 1'b1, 1'b0);
      done_c = -1;
      for (int c = 1; c < 40*n + 40 && done_c < 0; c++) begin
         step(rdy_of(mode, c), 1'(c == start2), 1'b0);
         if (mode == 0) begin
            chk({name, ":busy_t"},   64'(busy),   64'(n > 0 && c <= n + 2));
            chk({name, ":rd_en_t"},  64'(rd_en),  64'(c <= n));
            chk({name, ":ovalid_t"}, 64'(ovalid), 64'(c >= 3 && c <= n + 2));
            chk({name, ":done_t"},   64'(done),   64'(c == ((n == 0) ? 1 : n + 3)));
         end
         if (mode == 2 && c == 20) chk({name, ":stall_reads"}, 64'(issued_m), 64'd2);
         if (done) begin
            done_c = c;
            chk({name, ":busy_at_done"}, 64'(busy), 64'd0);
         end
      end
      chk({name, ":done_seen"}, 64'(done_c >= 0), 64'd1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      chk({name, ":busy_idle"}, 64'(busy),        64'd0);
      chk({name, ":accepted"},  64'(accepted_m),  64'(n));
      chk({name, ":issued"},    64'(issued_m),    64'(n));
      chk({name, ":one_done"},  64'(n_done),      64'd1);
      chk({name, ":leftover"},  64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; oready = 1'b0; nelems = '0;
      issued_m = 0; accepted_m = 0; n_done = 0; run_n = 0;
      prev_ov = 1'b0; prev_rdy = 1'b0; prev_data = '0;

      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      check_quiet("reset");

      run("basic4",  4, 0, -1, 1'b1);
      run("zero",    0, 0, -1, 1'b0);
      run("toggle8", 8, 1, -1, 1'b0);
      run("stall5",  5, 2, -1, 1'b0);
      run("restart", 3, 0,  2, 1'b0);

      // Reset asserted during cycle 4 of an 8-element run
      prep(8, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      for (int c = 1; c < 4; c++) step(1'b1, 1'b0, 1'b0);
      n_done = 0;
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0);
      check_quiet("mid_rst");
      exp_q.delete();
      issued_m = 0; accepted_m = 0; run_n = 0; prev_ov = 1'b0;
      for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0);
      chk("mid_rst:no_done", 64'(n_done), 64'd0);
      run("after_rst", 2, 0, -1, 1'b0);

      for (int k = 0; k < 6; k++) run("rand", $urandom_range(1, 40), 3, -1, 1'b0);
      run("full_len", MEMN, 0, -1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
